// File: rtl/trace_fill_collector.sv
// rtl/trace_fill_collector.sv - packs retired instructions into trace-cache fill bundles
module trace_fill_collector #(
  parameter int NRETIRE = 8,
  parameter int VA_SZ   = 48,
  parameter int DATA_SZ = 64,
  parameter int DEPTH   = 2*NRETIRE,
  parameter int TIMEOUT = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NRETIRE-1:0]           ret_valid,
  input  logic [NRETIRE*(VA_SZ-1)-1:0] ret_pc,
  input  logic [NRETIRE-1:0]           ret_short,
  input  logic [NRETIRE-1:0]           ret_branched,
  input  logic [NRETIRE*(VA_SZ-1)-1:0] ret_pc_dest,
  input  logic [NRETIRE*DATA_SZ-1:0]   ret_data,
  input  logic                         flush,
  output logic [NRETIRE-1:0]           out_valid,
  output logic [NRETIRE*(VA_SZ-1)-1:0] out_pc,
  output logic [NRETIRE-1:0]           out_short,
  output logic [NRETIRE-1:0]           out_branched,
  output logic [NRETIRE*(VA_SZ-1)-1:0] out_pc_dest,
  output logic [NRETIRE*DATA_SZ-1:0]   out_data,
  output logic [NRETIRE-1:0]           out_start,
  output logic [VA_SZ-2:0]             out_next,
  output logic                         busy,
  output logic [15:0]                  drop_count
);

  localparam int PW  = VA_SZ - 1;
  localparam int TOT = DEPTH + NRETIRE;
  localparam int CW  = $clog2(TOT + 1);
  localparam int IW  = $clog2(TIMEOUT + 1);
  localparam int NW  = $clog2(NRETIRE);

  typedef struct packed {
    logic [PW-1:0]      pc;
    logic               is_short;
    logic               branched;
    logic [PW-1:0]      pc_dest;
    logic [DATA_SZ-1:0] data;
    logic               start;
  } entry_t;

  function automatic logic [PW-1:0] seq_next(input entry_t e);
    if (e.branched) return e.pc_dest;
    return e.pc + (e.is_short ? PW'(1) : PW'(2));
  endfunction

  entry_t              stage_q [DEPTH];
  logic [CW-1:0]       cnt_q;
  logic [PW-1:0]       expect_q;
  logic                expect_valid_q;
  logic                force_start_q;
  logic [IW-1:0]       idle_q;
  logic [15:0]         drop_q;

  entry_t              inc_raw [NRETIRE];
  entry_t              inc     [NRETIRE];
  logic [NRETIRE-1:0]  inc_start;
  entry_t              comb_v  [TOT];
  entry_t              nstage  [DEPTH];
  entry_t              obundle [NRETIRE];
  logic [NRETIRE-1:0]  ovalid_d;
  logic [PW-1:0]       onext_d;
  logic [CW-1:0]       n_in, c_tot, p, e, remain, new_cnt, dropped, accepted;
  logic [NW-1:0]       last_idx;
  logic                emit;
  logic [IW-1:0]       idle_d;
  logic [16:0]         drop_sum;
  logic [15:0]         drop_d;

  always_comb begin
    for (int i = 0; i < NRETIRE; i++) begin
      inc_raw[i].pc       = ret_pc[i*PW +: PW];
      inc_raw[i].is_short = ret_short[i];
      inc_raw[i].branched = ret_branched[i];
      inc_raw[i].pc_dest  = ret_pc_dest[i*PW +: PW];
      inc_raw[i].data     = ret_data[i*DATA_SZ +: DATA_SZ];
      inc_raw[i].start    = 1'b0;
    end
  end

  // Slot 0 compares against the previous cycle's continuation; later slots against their neighbour.
  always_comb begin
    inc_start    = '0;
    inc_start[0] = force_start_q || (expect_valid_q && (inc_raw[0].pc != expect_q));
    for (int i = 1; i < NRETIRE; i++)
      inc_start[i] = inc_raw[i].pc != seq_next(inc_raw[i-1]);
  end

  always_comb begin
    for (int i = 0; i < NRETIRE; i++) begin
      inc[i]       = inc_raw[i];
      inc[i].start = inc_start[i];
    end
  end

  always_comb begin
    n_in = '0;
    for (int i = 0; i < NRETIRE; i++)
      if (ret_valid[i]) n_in = n_in + CW'(1);
    c_tot = cnt_q + n_in;

    for (int j = 0; j < TOT; j++) comb_v[j] = '0;
    for (int j = 0; j < DEPTH; j++)
      if (CW'(j) < cnt_q) comb_v[j] = stage_q[j];
    for (int i = 0; i < NRETIRE; i++)
      if (CW'(i) < n_in) comb_v[cnt_q + CW'(i)] = inc[i];

    // Prefix stops just before the first trace start beyond position 0.
    p = (c_tot < CW'(NRETIRE)) ? c_tot : CW'(NRETIRE);
    for (int j = NRETIRE - 1; j >= 1; j--)
      if ((CW'(j) < c_tot) && comb_v[j].start) p = CW'(j);

    emit = (c_tot != '0) &&
           ((p == CW'(NRETIRE)) || (p < c_tot) || flush || (idle_q == IW'(TIMEOUT)));
    e        = emit ? p : '0;
    remain   = c_tot - e;
    new_cnt  = (remain > CW'(DEPTH)) ? CW'(DEPTH) : remain;
    dropped  = remain - new_cnt;
    accepted = n_in - dropped;
    last_idx = (accepted == '0) ? '0 : NW'(accepted - CW'(1));

    for (int j = 0; j < DEPTH; j++)
      nstage[j] = (CW'(j) < new_cnt) ? comb_v[CW'(j) + e] : '0;

    for (int j = 0; j < NRETIRE; j++) begin
      ovalid_d[j] = emit && (CW'(j) < p);
      obundle[j]  = ovalid_d[j] ? comb_v[j] : '0;
    end
    onext_d = seq_next(comb_v[(p == '0) ? '0 : (p - CW'(1))]);

    if ((n_in != '0) || emit)
      idle_d = '0;
    else if ((c_tot != '0) && (idle_q != IW'(TIMEOUT)))
      idle_d = idle_q + IW'(1);
    else
      idle_d = idle_q;

    drop_sum = {1'b0, drop_q} + {{(17-CW){1'b0}}, dropped};
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q        <= '{default: '0};
      cnt_q          <= '0;
      expect_q       <= '0;
      expect_valid_q <= 1'b0;
      force_start_q  <= 1'b1;
      idle_q         <= '0;
      drop_q         <= '0;
      out_valid      <= '0;
      out_pc         <= '0;
      out_short      <= '0;
      out_branched   <= '0;
      out_pc_dest    <= '0;
      out_data       <= '0;
      out_start      <= '0;
      out_next       <= '0;
    end else begin
      stage_q <= nstage;
      cnt_q   <= new_cnt;
      idle_q  <= idle_d;
      drop_q  <= drop_d;
      if (accepted != '0) begin
        expect_q       <= seq_next(inc[last_idx]);
        expect_valid_q <= 1'b1;
      end
      if (flush || (dropped != '0))
        force_start_q <= 1'b1;
      else if (accepted != '0)
        force_start_q <= 1'b0;
      out_valid <= ovalid_d;
      if (emit) begin
        for (int j = 0; j < NRETIRE; j++) begin
          out_pc[j*PW +: PW]                <= obundle[j].pc;
          out_short[j]                      <= obundle[j].is_short;
          out_branched[j]                   <= obundle[j].branched;
          out_pc_dest[j*PW +: PW]           <= obundle[j].pc_dest;
          out_data[j*DATA_SZ +: DATA_SZ]    <= obundle[j].data;
          out_start[j]                      <= obundle[j].start;
        end
        out_next <= onext_d;
      end
    end
  end

  assign busy       = (cnt_q != '0);
  assign drop_count = drop_q;

endmodule

// File: tb/tb_trace_fill_collector.sv
// tb/tb_trace_fill_collector.sv - directed checks for trace_fill_collector
module tb_trace_fill_collector;
  localparam int N  = 8;
  localparam int PW = 47;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    ret_valid, ret_short, ret_branched;
  logic [N*PW-1:0] ret_pc, ret_pc_dest;
  logic [N*DW-1:0] ret_data;
  logic            flush;
  logic [N-1:0]    out_valid, out_short, out_branched, out_start;
  logic [N*PW-1:0] out_pc, out_pc_dest;
  logic [N*DW-1:0] out_data;
  logic [PW-1:0]   out_next;
  logic            busy;
  logic [15:0]     drop_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trace_fill_collector dut (
    .clk(clk), .reset(reset),
    .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_short(ret_short),
    .ret_branched(ret_branched), .ret_pc_dest(ret_pc_dest), .ret_data(ret_data),
    .flush(flush),
    .out_valid(out_valid), .out_pc(out_pc), .out_short(out_short),
    .out_branched(out_branched), .out_pc_dest(out_pc_dest), .out_data(out_data),
    .out_start(out_start), .out_next(out_next), .busy(busy), .drop_count(drop_count)
  );

  function automatic logic [PW-1:0] hw(input logic [47:0] b);
    return b[47:1];
  endfunction

  function automatic logic [PW-1:0] opc(input int i);
    return out_pc[i*PW +: PW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    ret_valid = '0; ret_short = '0; ret_branched = '0;
    ret_pc = '0; ret_pc_dest = '0; ret_data = '0; flush = 1'b0;
  endtask

  task automatic put(input int i, input logic [47:0] bpc, input logic sh, input logic br,
                     input logic [47:0] bdest);
    ret_valid[i]            = 1'b1;
    ret_short[i]            = sh;
    ret_branched[i]         = br;
    ret_pc[i*PW +: PW]      = bpc[47:1];
    ret_pc_dest[i*PW +: PW] = bdest[47:1];
    ret_data[i*DW +: DW]    = {16'hA5A5, bpc};
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clr_in();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clr_in();
    tick(); tick();
    checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL reset_valid got %h want 00", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (drop_count !== 16'h0) begin errors++; $display("FAIL reset_drop got %h want 0", drop_count); end
    checks++; if (out_pc !== '0 || out_next !== '0) begin errors++; $display("FAIL reset_data got pc0 %h next %h want 0", opc(0), out_next); end
    reset = 1'b0;
  endtask

  task automatic test_contiguous_timeout();
    int n;
    do_reset();
    for (int i = 0; i < 4; i++) put(i, 48'h1000 + 48'(4*i), 1'b0, 1'b0, 48'h0);
    tick(); clr_in();
    checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL fill1_valid got %h want 00", out_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fill1_busy got %b want 1", busy); end
    for (int i = 0; i < 4; i++) put(i, 48'h1010 + 48'(4*i), 1'b0, 1'b0, 48'h0);
    tick(); clr_in();
    checks++; if (out_valid !== 8'hFF) begin errors++; $display("FAIL fill2_valid got %h want ff", out_valid); end
    checks++; if (opc(0) !== hw(48'h1000) || opc(7) !== hw(48'h101C)) begin errors++; $display("FAIL fill2_pc got %h/%h want %h/%h", opc(0), opc(7), hw(48'h1000), hw(48'h101C)); end
    checks++; if (out_start !== 8'h01) begin errors++; $display("FAIL fill2_start got %h want 01", out_start); end
    checks++; if (out_next !== hw(48'h1020)) begin errors++; $display("FAIL fill2_next got %h want %h", out_next, hw(48'h1020)); end
    for (int i = 0; i < 4; i++) put(i, 48'h1020 + 48'(4*i), 1'b0, 1'b0, 48'h0);
    tick(); clr_in();
    checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL fill3_valid got %h want 00", out_valid); end
    n = 0;
    while (out_valid === 8'h00 && n < 12) begin tick(); n++; end
    checks++; if (n != 5) begin errors++; $display("FAIL timeout_latency got %0d want 5", n); end
    checks++; if (out_valid !== 8'h0F) begin errors++; $display("FAIL timeout_valid got %h want 0f", out_valid); end
    checks++; if (opc(0) !== hw(48'h1020) || opc(3) !== hw(48'h102C)) begin errors++; $display("FAIL timeout_pc got %h/%h want %h/%h", opc(0), opc(3), hw(48'h1020), hw(48'h102C)); end
    checks++; if (out_start !== 8'h00) begin errors++; $display("FAIL timeout_start got %h want 00", out_start); end
    checks++; if (out_next !== hw(48'h1030)) begin errors++; $display("FAIL timeout_next got %h want %h", out_next, hw(48'h1030)); end
  endtask

  task automatic test_mixed_widths();
    do_reset();
    put(0, 48'h1000, 1'b1, 1'b0, 48'h0);
    put(1, 48'h1002, 1'b1, 1'b0, 48'h0);
    put(2, 48'h1004, 1'b0, 1'b0, 48'h0);
    flush = 1'b1;
    tick(); clr_in();
    checks++; if (out_valid !== 8'h07) begin errors++; $display("FAIL mixed_valid got %h want 07", out_valid); end
    checks++; if (out_start !== 8'h01) begin errors++; $display("FAIL mixed_start got %h want 01", out_start); end
    checks++; if (out_short !== 8'h03) begin errors++; $display("FAIL mixed_short got %h want 03", out_short); end
    checks++; if (out_next !== hw(48'h1008)) begin errors++; $display("FAIL mixed_next got %h want %h", out_next, hw(48'h1008)); end
  endtask

  task automatic test_break();
    do_reset();
    for (int i = 0; i < 4; i++) put(i, 48'h4000 + 48'(4*i), 1'b0, i == 3, 48'h2000);
    for (int i = 4; i < 8; i++) put(i, 48'h3000 + 48'(4*(i-4)), 1'b0, 1'b0, 48'h0);
    tick(); clr_in();
    checks++; if (out_valid !== 8'h0F) begin errors++; $display("FAIL break_valid got %h want 0f", out_valid); end
    checks++; if (out_branched !== 8'h08 || out_pc_dest[3*PW +: PW] !== hw(48'h2000)) begin errors++; $display("FAIL break_branch got %h dest %h want 08 %h", out_branched, out_pc_dest[3*PW +: PW], hw(48'h2000)); end
    checks++; if (out_next !== hw(48'h2000)) begin errors++; $display("FAIL break_next got %h want %h", out_next, hw(48'h2000)); end
    checks++; if (out_data[1*DW +: DW] !== 64'hA5A5_0000_0000_4004) begin errors++; $display("FAIL break_data got %h want a5a5000000004004", out_data[1*DW +: DW]); end
    for (int i = 0; i < 8; i++) put(i, 48'h3010 + 48'(4*i), 1'b0, 1'b0, 48'h0);
    tick(); clr_in();
    checks++; if (out_valid !== 8'hFF) begin errors++; $display("FAIL break2_valid got %h want ff", out_valid); end
    checks++; if (opc(0) !== hw(48'h3000) || out_start !== 8'h01) begin errors++; $display("FAIL break2_head got pc %h start %h want %h 01", opc(0), out_start, hw(48'h3000)); end
    checks++; if (out_next !== hw(48'h3020)) begin errors++; $display("FAIL break2_next got %h want %h", out_next, hw(48'h3020)); end
  endtask

  task automatic test_overflow();
    int n;
    logic found;
    logic [15:0] want_drop;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 8; i++) put(i, 48'h10000 + 48'((c*8+i)*256), 1'b0, 1'b0, 48'h0);
      tick(); clr_in();
      want_drop = (c == 2) ? 16'd5 : 16'd0;
      checks++; if (out_valid !== 8'h01 || opc(0) !== hw(48'h10000 + 48'(c*256))) begin errors++; $display("FAIL ovf_bundle c%0d got %h pc %h want 01 %h", c, out_valid, opc(0), hw(48'h10000 + 48'(c*256))); end
      checks++; if (drop_count !== want_drop) begin errors++; $display("FAIL ovf_drop c%0d got %0d want %0d", c, drop_count, want_drop); end
    end
    put(0, 48'h11204, 1'b0, 1'b0, 48'h0);
    tick(); clr_in();
    checks++; if (out_valid !== 8'h01 || opc(0) !== hw(48'h10300)) begin errors++; $display("FAIL ovf_c4 got %h pc %h want 01 %h", out_valid, opc(0), hw(48'h10300)); end
    checks++; if (drop_count !== 16'd5) begin errors++; $display("FAIL ovf_c4_drop got %0d want 5", drop_count); end
    n = 0; found = 1'b0;
    while (!found && n < 40) begin
      tick(); n++;
      if (out_valid !== 8'h00 && opc(0) === hw(48'h11204)) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL ovf_drain got found=%b want 1 within 40 cycles", found); end
    checks++; if (out_start[0] !== 1'b1 || out_valid !== 8'h01) begin errors++; $display("FAIL ovf_next_start got start %h valid %h want 01 01", out_start, out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovf_busy got %b want 0", busy); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) put(i, 48'h5000 + 48'(4*i), 1'b0, 1'b0, 48'h0);
    tick(); clr_in();
    checks++; if (out_valid !== 8'h00 || busy !== 1'b1) begin errors++; $display("FAIL flush_pre got %h busy %b want 00 1", out_valid, busy); end
    flush = 1'b1;
    tick(); clr_in();
    checks++; if (out_valid !== 8'h07 || out_start !== 8'h01) begin errors++; $display("FAIL flush_emit got %h start %h want 07 01", out_valid, out_start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", busy); end
    put(0, 48'h500C, 1'b0, 1'b0, 48'h0);
    tick(); clr_in();
    checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL flush_hold got %h want 00", out_valid); end
    flush = 1'b1;
    tick(); clr_in();
    checks++; if (out_valid !== 8'h01 || opc(0) !== hw(48'h500C) || out_start !== 8'h01) begin errors++; $display("FAIL flush_restart got %h pc %h start %h want 01 %h 01", out_valid, opc(0), out_start, hw(48'h500C)); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) put(i, 48'h6000 + 48'(4*i), 1'b0, 1'b0, 48'h0);
    tick(); clr_in();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_pre got %b want 1", busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (busy !== 1'b0 || out_valid !== 8'h00) begin errors++; $display("FAIL rmid_after got busy %b valid %h want 0 00", busy, out_valid); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (out_valid !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL rmid_quiet c%0d got %h busy %b want 00 0", c, out_valid, busy); end
    end
    put(0, 48'h6014, 1'b0, 1'b0, 48'h0);
    flush = 1'b1;
    tick(); clr_in();
    checks++; if (out_valid !== 8'h01 || opc(0) !== hw(48'h6014) || out_start !== 8'h01) begin errors++; $display("FAIL rmid_first got %h pc %h start %h want 01 %h 01", out_valid, opc(0), out_start, hw(48'h6014)); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] want_start;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 8; i++) put(i, 48'h8000 + 48'(c*32 + i*4), 1'b0, 1'b0, 48'h0);
      tick(); clr_in();
      want_start = (c == 0) ? 8'h01 : 8'h00;
      checks++; if (out_valid !== 8'hFF || opc(0) !== hw(48'h8000 + 48'(c*32))) begin errors++; $display("FAIL b2b c%0d got %h pc %h want ff %h", c, out_valid, opc(0), hw(48'h8000 + 48'(c*32))); end
      checks++; if (out_start !== want_start || busy !== 1'b0) begin errors++; $display("FAIL b2b_start c%0d got %h busy %b want %h 0", c, out_start, busy, want_start); end
    end
  endtask

  initial begin
    test_reset();
    test_contiguous_timeout();
    test_mixed_widths();
    test_break();
    test_overflow();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
